// File: rtl/stride_nd_counter.sv
// stride_nd_counter
//   N-dimensional strided loop counter for window / feature-map index generation.
//   NDIM nested counters (dim 0 innermost). Each dimension steps by its stride and
//   wraps to zero with a carry into the next dimension once cnt+stride reaches its
//   exclusive bound. Tuples are presented with a valid/ready handshake.
//
// Ports
//   clk         clock, all state on rising edge
//   reset       asynchronous active-low reset
//   start       begin a sequence, sampled only in IDLE
//   clr         synchronous abort to IDLE (no done pulse)
//   cfg_stride  per-dim stride, dim d at [d*STRIDEW +: STRIDEW]
//   cfg_bound   per-dim exclusive bound, dim d at [d*CNTW +: CNTW]
//   out_cnt     current index tuple, same packing as cfg_bound
//   out_valid   out_cnt holds a valid tuple
//   out_ready   consumer accepts on out_valid & out_ready
//   out_last    current tuple is the final one
//   busy        high while running
//   done        one-cycle pulse at end of sequence (normal or config error)
//   err         sticky config error, cleared by next accepted start or clr
//
// STRIDEW must not exceed CNTW: the stride is zero-extended into the CNTW+1 bit sum.

// Per-dimension step/wrap logic. Purely combinational; the registers live in the top.
module stride_nd_dim #(
  parameter int CNTW    = 16,
  parameter int STRIDEW = 8
) (
  input  logic [CNTW-1:0]    cnt,
  input  logic [STRIDEW-1:0] stride,
  input  logic [CNTW-1:0]    bound,
  input  logic               carry_in,
  output logic [CNTW-1:0]    cnt_next,
  output logic               wrap,
  output logic               carry_out
);
  // One extra bit so cnt+stride never overflows before the bound compare.
  logic [CNTW:0] sum;

  assign sum       = {1'b0, cnt} + {{(CNTW+1-STRIDEW){1'b0}}, stride};
  assign wrap      = (sum >= {1'b0, bound});
  assign cnt_next  = carry_in ? (wrap ? '0 : sum[CNTW-1:0]) : cnt;
  assign carry_out = carry_in & wrap;
endmodule

module stride_nd_counter #(
  parameter int NDIM    = 2,
  parameter int CNTW    = 16,
  parameter int STRIDEW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    clr,
  input  logic [NDIM*STRIDEW-1:0] cfg_stride,
  input  logic [NDIM*CNTW-1:0]    cfg_bound,
  output logic [NDIM*CNTW-1:0]    out_cnt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [NDIM-1:0][CNTW-1:0]    cnt_q, cnt_d, cnt_step;
  logic [NDIM-1:0][STRIDEW-1:0] stride_q;
  logic [NDIM-1:0][CNTW-1:0]    bound_q;
  logic [NDIM-1:0]              wrap;
  logic [NDIM-1:0]              cfg_zero;
  // carry[0] is the accept strobe; carry[NDIM] is set only when every dim wraps on
  // an accept, i.e. the final tuple was just consumed.
  logic [NDIM:0]                carry;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic                         cfg_load;
  logic                         run;

  assign run      = (state_q == RUN);
  assign carry[0] = run & out_ready;

  genvar d;
  generate
    for (d = 0; d < NDIM; d++) begin : g_dim
      assign cfg_zero[d] = (cfg_stride[d*STRIDEW +: STRIDEW] == '0) |
                           (cfg_bound[d*CNTW +: CNTW] == '0);

      stride_nd_dim #(
        .CNTW    (CNTW),
        .STRIDEW (STRIDEW)
      ) u_dim (
        .cnt       (cnt_q[d]),
        .stride    (stride_q[d]),
        .bound     (bound_q[d]),
        .carry_in  (carry[d]),
        .cnt_next  (cnt_step[d]),
        .wrap      (wrap[d]),
        .carry_out (carry[d+1])
      );
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = err_q;
    cfg_load = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cfg_load = 1'b1;
            if (|cfg_zero) begin
              // Bad config never enters RUN; report through err + done.
              err_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              err_d   = 1'b0;
              cnt_d   = '0;
            end
          end
        end
        RUN: begin
          if (carry[NDIM]) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_step;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      stride_q <= '0;
      bound_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (cfg_load) begin
        stride_q <= cfg_stride;
        bound_q  <= cfg_bound;
      end
    end
  end

  assign out_cnt   = cnt_q;
  assign out_valid = run;
  assign busy      = run;
  // Gated by run: in IDLE the wrap terms are meaningless (e.g. zero regs after reset).
  assign out_last  = run & (&wrap);
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_stride_nd_counter.sv
module tb_stride_nd_counter;
  localparam int NDIM = 2, CNTW = 16, STRIDEW = 8;

  logic                    clk = 1'b0;
  logic                    reset, start, clr, out_ready;
  logic [NDIM*STRIDEW-1:0] cfg_stride;
  logic [NDIM*CNTW-1:0]    cfg_bound;
  logic [NDIM*CNTW-1:0]    out_cnt;
  logic                    out_valid, out_last, busy, done, err;

  stride_nd_counter #(.NDIM(NDIM), .CNTW(CNTW), .STRIDEW(STRIDEW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .clr        (clr),
    .cfg_stride (cfg_stride),
    .cfg_bound  (cfg_bound),
    .out_cnt    (out_cnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  typedef struct {
    int s0, s1, b0, b1;
    int rdy_pct;
    int exp_n;
    int exp_l0, exp_l1;
    bit exp_err;
  } vec_t;

  typedef struct { int c0, c1; } tup_t;

  vec_t vecs[$];
  tup_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain nested loops over the index space, outer dim slowest.
  task automatic build_model(input int s0, input int s1, input int b0, input int b1);
    exp_q.delete();
    for (int i1 = 0; i1 < b1; i1 += s1)
      for (int i0 = 0; i0 < b0; i0 += s0)
        exp_q.push_back('{i0, i1});
  endtask

  task automatic drive_cfg(input int s0, input int s1, input int b0, input int b1);
    cfg_stride = {8'(s1), 8'(s0)};
    cfg_bound  = {16'(b1), 16'(b0)};
  endtask

  task automatic run_vec(input vec_t v, input bit rand_start);
    int          idx, budget, n_acc;
    bit          rdy, fin;
    logic [31:0] ev, last_cnt;
    n_acc = 0; idx = 0; fin = 0; last_cnt = '1;
    if (!v.exp_err) build_model(v.s0, v.s1, v.b0, v.b1);
    drive_cfg(v.s0, v.s1, v.b0, v.b1);
    start = 1; clr = 0; out_ready = 0;
    step();
    start = 0;
    // Later cfg changes must not affect the run.
    cfg_stride = 16'($urandom);
    cfg_bound  = 32'($urandom);
    if (v.exp_err) begin
      chk("err_set", err, 1);
      chk("err_done", done, 1);
      chk("err_novalid", out_valid, 0);
      step();
      chk("err_done_1cyc", done, 0);
      chk("err_sticky", err, 1);
      chk("err_novalid2", out_valid, 0);
      return;
    end
    chk("run_valid", out_valid, 1);
    chk("run_busy", busy, 1);
    chk("run_err_clr", err, 0);
    budget = exp_q.size() * 30 + 50;
    while (!fin && budget > 0) begin
      budget--;
      rdy = ($urandom_range(0, 99) < v.rdy_pct);
      out_ready = rdy;
      start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (idx < exp_q.size()) begin
        ev = {16'(exp_q[idx].c1), 16'(exp_q[idx].c0)};
        chk("tuple", out_cnt, ev);
        chk("last_flag", out_last, (idx == exp_q.size() - 1));
      end else begin
        chk("extra_tuple", idx, exp_q.size() - 1);
      end
      chk("valid_hold", out_valid, 1);
      chk("no_early_done", done, 0);
      if (rdy) begin
        n_acc++;
        if (out_last) begin
          fin = 1;
          last_cnt = out_cnt;
        end
      end
      step();
      if (rdy) idx++;
    end
    out_ready = 0; start = 0;
    if (!fin) chk("timeout", 0, 1);
    chk("ntuples", n_acc, v.exp_n);
    chk("final_tuple", last_cnt, {16'(v.exp_l1), 16'(v.exp_l0)});
    chk("end_done", done, 1);
    chk("end_valid", out_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_cnt", out_cnt, 0);
    chk("end_last", out_last, 0);
    step();
    chk("done_1cyc", done, 0);
  endtask

  initial begin
    vec_t v;
    //            s0   s1  b0      b1 rdy  n    l0     l1 err
    vecs.push_back('{1,   1, 3,      2, 100, 6,   2,     1, 0});
    vecs.push_back('{2,   1, 5,      2, 100, 6,   4,     1, 0});
    vecs.push_back('{1,   1, 3,      2, 50,  6,   2,     1, 0});
    vecs.push_back('{3,   2, 7,      5, 70,  9,   6,     4, 0});
    vecs.push_back('{5,   4, 3,      2, 100, 1,   0,     0, 0});
    vecs.push_back('{1,   1, 0,      4, 100, 0,   0,     0, 1});
    vecs.push_back('{0,   1, 4,      4, 100, 0,   0,     0, 1});
    vecs.push_back('{255, 1, 16'hFFFF, 1, 100, 257, 65280, 0, 0});

    reset = 0; start = 0; clr = 0; out_ready = 0;
    cfg_stride = '0; cfg_bound = '0;
    #12;
    chk("rst_cnt", out_cnt, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1;
    step();

    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    // err left set by last error vector? Re-create it and clear with clr.
    run_vec(vecs[5], 1'b0);
    clr = 1;
    step();
    clr = 0;
    chk("clr_clears_err", err, 0);
    chk("clr_no_done", done, 0);

    // Randomized configs, random ready, random start pulses during RUN.
    for (int r = 0; r < 12; r++) begin
      v.s0 = $urandom_range(1, 4); v.s1 = $urandom_range(1, 3);
      v.b0 = $urandom_range(1, 9); v.b1 = $urandom_range(1, 5);
      v.rdy_pct = $urandom_range(30, 100);
      v.exp_err = 0;
      build_model(v.s0, v.s1, v.b0, v.b1);
      v.exp_n  = exp_q.size();
      v.exp_l0 = exp_q[exp_q.size()-1].c0;
      v.exp_l1 = exp_q[exp_q.size()-1].c1;
      run_vec(v, 1'b1);
    end

    // clr after 3rd accept, start in RUN ignored, clr beats start.
    drive_cfg(1, 1, 3, 2);
    start = 1; step(); start = 0;
    out_ready = 1; start = 1;
    step();
    start = 0;
    chk("start_in_run_ignored", out_cnt, {16'd0, 16'd1});
    step();
    step();
    chk("third_tuple", out_cnt, {16'd1, 16'd0});
    clr = 1; start = 1;
    step();
    clr = 0; start = 0; out_ready = 0;
    chk("clr_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_cnt", out_cnt, 0);
    step();
    chk("clr_wins_start", out_valid, 0);
    chk("clr_no_done2", done, 0);

    // clr together with final accept: no done.
    drive_cfg(5, 4, 3, 2);
    start = 1; step(); start = 0;
    chk("single_last", out_last, 1);
    out_ready = 1; clr = 1;
    step();
    out_ready = 0; clr = 0;
    chk("clr_final_done", done, 0);
    chk("clr_final_valid", out_valid, 0);
    step();
    chk("clr_final_done2", done, 0);

    // Async reset mid-run.
    drive_cfg(255, 1, 16'hFFFF, 1);
    start = 1; step(); start = 0;
    out_ready = 1;
    repeat (10) step();
    chk("mid_run_cnt", out_cnt, {16'd0, 16'd2550});
    #2 reset = 0;
    #1;
    chk("async_cnt", out_cnt, 0);
    chk("async_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_last", out_last, 0);
    #2 reset = 1;
    out_ready = 0;
    step();
    chk("post_reset_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
